regfile_master: RTL and testbench
=================================

Name: regfile_master

Overview:
- Command-driven initiator for the control-register file port (addr/din/ren/wen/dout).
- Accepts single register commands over a valid/ready request channel and sequences the register-port strobes.
- Returns read data or status on a valid/ready response channel.
- Supports READ, WRITE and read-modify-write SET/CLR bits. Sits between the host-side command source and the register file.

Parameters:
- NUM_REGS, 4, number of implemented registers; addresses >= NUM_REGS are rejected.
- RD_LATENCY, 0, extra cycles between ren assertion and valid rf_dout (legal 0..3).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request valid
- cmd_ready  output  1  block can accept a command
- cmd_op  input  2  e_rf_op: 0 READ, 1 WRITE, 2 SET, 3 CLR
- cmd_addr  input  8  register address
- cmd_data  input  8  write data (WRITE) or bit mask (SET/CLR)
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_data  output  8  read data (READ) or pre-modify value (SET/CLR); 0 for WRITE or error
- rsp_err  output  1  address out of range
- rf_addr  output  8  register-file address
- rf_din  output  8  register-file write data
- rf_ren  output  1  register-file read strobe
- rf_wen  output  1  register-file write strobe
- rf_dout  input  8  register-file read data

Interface: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values:
  - cmd_ready=0 during reset, 1 after.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - rf_addr=0, rf_din=0, rf_ren=0, rf_wen=0.
  - FSM state IDLE, latency counter 0.
- FSM states: IDLE, RD_WAIT, WRITE, RESP.
- cmd_ready = (state==IDLE). A command is accepted on cmd_valid&&cmd_ready in cycle T; op, addr and data are latched.
- IDLE, on accept:
  - If addr >= NUM_REGS: go to RESP with rsp_err=1 and rsp_data=0. No rf strobes are issued.
  - WRITE: go to WRITE with rf_din=cmd_data.
  - READ/SET/CLR: go to RD_WAIT.
  - rf_addr is loaded with cmd_addr on accept and held until the next accept.
- RD_WAIT:
  - rf_ren=1 for RD_LATENCY+1 cycles (T+1 .. T+1+RD_LATENCY). rf_dout is sampled in the last of these cycles.
  - READ: go to RESP with rsp_data=sample.
  - SET: rf_din = sample | mask, go to WRITE.
  - CLR: rf_din = sample & ~mask, go to WRITE.
  - For SET/CLR, rsp_data = sample.
- WRITE: rf_wen=1 for exactly one cycle, then go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid the next cycle.
- rf_ren and rf_wen are never asserted together and are registered outputs.
- Latency (RD_LATENCY=0, rsp_ready held high):
  - WRITE: wen at T+1, rsp_valid at T+2.
  - READ: ren at T+1, rsp_valid at T+2.
  - SET/CLR: ren at T+1, wen at T+2, rsp_valid at T+3.
  - Error: rsp_valid at T+1.
  - Each RD_LATENCY step adds 1 cycle to READ/SET/CLR.
- Throughput: one outstanding command. The next accept is possible in the cycle after the response handshake.
- Backpressure: rsp_ready low holds RESP indefinitely with no further rf activity.
- Reset mid-operation: immediately returns to IDLE, drops strobes, and discards the in-flight command and its response. A partially completed SET/CLR issues no write.
- Address width: only addr < NUM_REGS is legal; no wrap-around or aliasing.

Decomposition:
- package_ctrlreg gains:
  - typedef enum logic [1:0] e_rf_op (RF_OP_READ, RF_OP_WRITE, RF_OP_SET, RF_OP_CLR)
  - typedef enum e_rfm_state (IDLE, RD_WAIT, WRITE, RESP)
  - localparam RF_NUM_REGS=4, shared with the register file's initial-value constant.
- No sub-module: a single FSM with a 2-bit latency counter.

Test Plan:
- Reset, then READ addr 2 -> ren one cycle at T+1, rsp_valid T+2, rsp_data=8'hFF, rsp_err=0.
- WRITE addr 1 data 8'h5A, then READ addr 1 -> wen one cycle with rf_addr=1 and rf_din=8'h5A; read returns 8'h5A.
- Sequence on addr 3 (reg=8'h0F):
  - SET mask 8'hC0 -> rsp_data 8'h0F, reg becomes 8'hCF.
  - CLR mask 8'h03 -> rsp_data 8'hCF, reg becomes 8'hCC.
- READ addr 8'h04 -> rsp_err=1, rsp_data=0 at T+1; no rf_ren or rf_wen.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0; accept occurs only after the handshake.
- rst_n asserted during SET at RD_WAIT -> all outputs return to reset values immediately; rf_wen is never asserted and the register is unchanged.
- RD_LATENCY=2 READ -> ren held for 3 cycles, rsp_valid at T+4.

Source files
------------

// File: rtl/regfile_master_pkg.sv
// Shared types and constants for the control-register file and its command initiator.
package regfile_master_pkg;

    // Number of implemented control registers; the register file sizes its
    // initial-value table from this same constant.
    localparam int RF_NUM_REGS = 4;
    localparam int RF_DATA_W   = 8;
    localparam int RF_ADDR_W   = 8;

    // Register command opcodes as carried on cmd_op.
    typedef enum logic [1:0] {
        RF_OP_READ  = 2'd0,
        RF_OP_WRITE = 2'd1,
        RF_OP_SET   = 2'd2,
        RF_OP_CLR   = 2'd3
    } e_rf_op;

    // Initiator sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2,
        RESP    = 2'd3
    } e_rfm_state;

    // Read-modify-write update: SET ors the mask in, CLR clears the masked bits.
    function automatic logic [RF_DATA_W-1:0] rf_modify(
        input e_rf_op               op,
        input logic [RF_DATA_W-1:0] cur,
        input logic [RF_DATA_W-1:0] mask
    );
        if (op == RF_OP_CLR) begin
            return cur & ~mask;
        end
        return cur | mask;
    endfunction

endpackage

// File: rtl/regfile_master.sv
// Command-driven initiator for the control-register file port. Takes one
// READ/WRITE/SET/CLR command at a time, sequences rf_ren/rf_wen, and returns
// read data (or the pre-modify value) with an out-of-range error flag.
module regfile_master
    import regfile_master_pkg::*;
#(
    parameter int NUM_REGS   = RF_NUM_REGS,
    parameter int RD_LATENCY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] rf_addr,
    output logic [7:0] rf_din,
    output logic       rf_ren,
    output logic       rf_wen,
    input  logic [7:0] rf_dout
);

    // Address compare is done one bit wider so NUM_REGS up to 256 is representable.
    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
    // Value of the latency counter in the cycle rf_dout is sampled.
    localparam logic [1:0] LAST_RD    = 2'(RD_LATENCY);

    e_rfm_state state_q, state_d;
    logic [1:0] lat_cnt_q, lat_cnt_d;
    e_rf_op     op_q, op_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] rf_addr_q, rf_addr_d;
    logic [7:0] rf_din_q, rf_din_d;
    logic       rf_ren_q, rf_ren_d;
    logic       rf_wen_q, rf_wen_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;

    // Next-state and next-output decode for the single command sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        op_d        = op_q;
        mask_d      = mask_q;
        rf_addr_d   = rf_addr_q;
        rf_din_d    = rf_din_q;
        rf_ren_d    = 1'b0;
        rf_wen_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d      = e_rf_op'(cmd_op);
                    mask_d    = cmd_data;
                    rf_addr_d = cmd_addr;
                    lat_cnt_d = 2'd0;
                    if ({1'b0, cmd_addr} >= NUM_REGS_W) begin
                        // Out of range: answer immediately, never touch the register file.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 8'h00;
                    end else if (e_rf_op'(cmd_op) == RF_OP_WRITE) begin
                        state_d    = WRITE;
                        rf_din_d   = cmd_data;
                        rf_wen_d   = 1'b1;
                        rsp_err_d  = 1'b0;
                        rsp_data_d = 8'h00;
                    end else begin
                        state_d   = RD_WAIT;
                        rf_ren_d  = 1'b1;
                        rsp_err_d = 1'b0;
                    end
                end
            end

            RD_WAIT: begin
                if (lat_cnt_q == LAST_RD) begin
                    // Last ren cycle: rf_dout is valid now.
                    rsp_data_d = rf_dout;
                    if (op_q == RF_OP_READ) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d  = WRITE;
                        rf_din_d = rf_modify(op_q, rf_dout, mask_q);
                        rf_wen_d = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                    rf_ren_d  = 1'b1;
                end
            end

            WRITE: begin
                // The single wen cycle is the one spent in this state.
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output flops; reset drops strobes and discards any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 2'd0;
            op_q        <= RF_OP_READ;
            mask_q      <= 8'h00;
            rf_addr_q   <= 8'h00;
            rf_din_q    <= 8'h00;
            rf_ren_q    <= 1'b0;
            rf_wen_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            op_q        <= op_d;
            mask_q      <= mask_d;
            rf_addr_q   <= rf_addr_d;
            rf_din_q    <= rf_din_d;
            rf_ren_q    <= rf_ren_d;
            rf_wen_q    <= rf_wen_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Ready only in IDLE and never while reset is held.
    assign cmd_ready = (state_q == IDLE) && rst_n;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rf_addr   = rf_addr_q;
    assign rf_din    = rf_din_q;
    assign rf_ren    = rf_ren_q;
    assign rf_wen    = rf_wen_q;

endmodule

// File: tb/tb_regfile_master.sv
// Self-checking bench for regfile_master: one instance with RD_LATENCY=0 and
// one with RD_LATENCY=2, each attached to a small register-file model.
module tb_regfile_master;
    import regfile_master_pkg::*;

    localparam int LAT [2] = '{0, 2};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    e_rf_op     cmd_op    [2];
    logic [7:0] cmd_addr  [2];
    logic [7:0] cmd_data  [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_data  [2];
    logic       rsp_err   [2];
    logic [7:0] rf_addr   [2];
    logic [7:0] rf_din    [2];
    logic       rf_ren    [2];
    logic       rf_wen    [2];
    logic [7:0] rf_dout   [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_master #(.NUM_REGS(4), .RD_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_err(rsp_err[0]), .rf_addr(rf_addr[0]), .rf_din(rf_din[0]),
        .rf_ren(rf_ren[0]), .rf_wen(rf_wen[0]), .rf_dout(rf_dout[0])
    );

    regfile_master #(.NUM_REGS(4), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_err(rsp_err[1]), .rf_addr(rf_addr[1]), .rf_din(rf_din[1]),
        .rf_ren(rf_ren[1]), .rf_wen(rf_wen[1]), .rf_dout(rf_dout[1])
    );

    // Register-file models: initial contents r0=00 r1=00 r2=FF r3=0F.
    logic [7:0] mem [2][4] = '{'{8'h00, 8'h00, 8'hFF, 8'h0F}, '{8'h00, 8'h00, 8'hFF, 8'h0F}};
    int ren_run   [2] = '{0, 0};
    int wen_total [2] = '{0, 0};
    int overlap   [2] = '{0, 0};

    // Model writes, counts strobes, and tracks how long ren has been held.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rf_wen[i] && rf_addr[i] < 8'd4) mem[i][rf_addr[i][1:0]] <= rf_din[i];
            if (rf_wen[i]) wen_total[i] <= wen_total[i] + 1;
            if (rf_wen[i] && rf_ren[i]) overlap[i] <= overlap[i] + 1;
            ren_run[i] <= rf_ren[i] ? ren_run[i] + 1 : 0;
        end
    end

    // Read data is only valid once ren has been held for the read latency; garbage before.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rf_dout[i] = (rf_ren[i] && ren_run[i] >= LAT[i]) ? mem[i][rf_addr[i][1:0]] : 8'hEE;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one command with rsp_ready high and observe strobes until the response.
    task automatic run_cmd(input int s, input e_rf_op op, input logic [7:0] addr,
                           input logic [7:0] data, output logic [7:0] d, output logic e,
                           output int lat, output int ren_n, output int wen_n,
                           output logic [7:0] din_w, output logic addr_ok);
        d = 8'h00; e = 1'b0; lat = -1; ren_n = 0; wen_n = 0; din_w = 8'h00; addr_ok = 1'b1;
        @(negedge clk);
        cmd_valid[s] = 1'b1; cmd_op[s] = op; cmd_addr[s] = addr; cmd_data[s] = data;
        @(negedge clk);
        cmd_valid[s] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (rf_ren[s]) begin
                ren_n++;
                if (rf_addr[s] != addr) addr_ok = 1'b0;
            end
            if (rf_wen[s]) begin
                wen_n++;
                din_w = rf_din[s];
                if (rf_addr[s] != addr) addr_ok = 1'b0;
            end
            if (rsp_valid[s]) begin
                lat = k; d = rsp_data[s]; e = rsp_err[s];
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int         s;
        e_rf_op     op;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_d;
        logic       exp_e;
        int         exp_lat;
        int         exp_ren;
        int         exp_wen;
        logic [7:0] exp_din;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d, din_w;
        logic       e, addr_ok;
        int         lat, ren_n, wen_n, w0;

        vecs[0]  = '{0, RF_OP_READ,  8'h02, 8'h00, 8'hFF, 1'b0, 2, 1, 0, 8'h00};
        vecs[1]  = '{0, RF_OP_WRITE, 8'h01, 8'h5A, 8'h00, 1'b0, 2, 0, 1, 8'h5A};
        vecs[2]  = '{0, RF_OP_READ,  8'h01, 8'h00, 8'h5A, 1'b0, 2, 1, 0, 8'h00};
        vecs[3]  = '{0, RF_OP_SET,   8'h03, 8'hC0, 8'h0F, 1'b0, 3, 1, 1, 8'hCF};
        vecs[4]  = '{0, RF_OP_CLR,   8'h03, 8'h03, 8'hCF, 1'b0, 3, 1, 1, 8'hCC};
        vecs[5]  = '{0, RF_OP_READ,  8'h03, 8'h00, 8'hCC, 1'b0, 2, 1, 0, 8'h00};
        vecs[6]  = '{0, RF_OP_READ,  8'h04, 8'h00, 8'h00, 1'b1, 1, 0, 0, 8'h00};
        vecs[7]  = '{0, RF_OP_WRITE, 8'hFF, 8'hA5, 8'h00, 1'b1, 1, 0, 0, 8'h00};
        vecs[8]  = '{0, RF_OP_SET,   8'h00, 8'hFF, 8'h00, 1'b0, 3, 1, 1, 8'hFF};
        vecs[9]  = '{0, RF_OP_CLR,   8'h00, 8'h0F, 8'hFF, 1'b0, 3, 1, 1, 8'hF0};
        vecs[10] = '{1, RF_OP_READ,  8'h03, 8'h00, 8'h0F, 1'b0, 4, 3, 0, 8'h00};
        vecs[11] = '{1, RF_OP_SET,   8'h03, 8'hF0, 8'h0F, 1'b0, 5, 3, 1, 8'hFF};
        vecs[12] = '{1, RF_OP_READ,  8'h03, 8'h00, 8'hFF, 1'b0, 4, 3, 0, 8'h00};

        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0; cmd_op[i] = RF_OP_READ; cmd_addr[i] = 8'h00;
            cmd_data[i] = 8'h00; rsp_ready[i] = 1'b1;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        // Reset values
        check("reset cmd_ready", {31'd0, cmd_ready[0]}, 32'd0);
        check("reset rsp", {23'd0, rsp_valid[0], rsp_err[0], rsp_data[0]}, 32'd0);
        check("reset rf", {14'd0, rf_ren[0], rf_wen[0], rf_addr[0], rf_din[0]}, 32'd0);
        check("reset cmd_ready lat2", {31'd0, cmd_ready[1]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset cmd_ready", {31'd0, cmd_ready[0]}, 32'd1);

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            run_cmd(vecs[i].s, vecs[i].op, vecs[i].addr, vecs[i].data,
                    d, e, lat, ren_n, wen_n, din_w, addr_ok);
            check($sformatf("v%0d rsp_data", i), {24'd0, d}, {24'd0, vecs[i].exp_d});
            check($sformatf("v%0d rsp_err", i), {31'd0, e}, {31'd0, vecs[i].exp_e});
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d ren cycles", i), ren_n, vecs[i].exp_ren);
            check($sformatf("v%0d wen cycles", i), wen_n, vecs[i].exp_wen);
            check($sformatf("v%0d rf_addr", i), {31'd0, addr_ok}, 32'd1);
            if (vecs[i].exp_wen > 0)
                check($sformatf("v%0d rf_din", i), {24'd0, din_w}, {24'd0, vecs[i].exp_din});
        end
        check("mem0 r0", {24'd0, mem[0][0]}, 32'hF0);
        check("mem0 r1", {24'd0, mem[0][1]}, 32'h5A);
        check("mem0 r3", {24'd0, mem[0][3]}, 32'hCC);
        check("mem1 r3", {24'd0, mem[1][3]}, 32'hFF);

        // Backpressure: response held for 5 cycles with a command pending
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        cmd_valid[0] = 1'b1; cmd_op[0] = RF_OP_READ; cmd_addr[0] = 8'h02; cmd_data[0] = 8'h00;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            if (rsp_valid[0]) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("bp latency", lat, 2);
        cmd_valid[0] = 1'b1; cmd_op[0] = RF_OP_WRITE; cmd_addr[0] = 8'h00; cmd_data[0] = 8'h11;
        w0 = wen_total[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d hold", k),
                  {20'd0, rsp_valid[0], cmd_ready[0], rf_ren[0], rf_wen[0], rsp_data[0]},
                  {20'd0, 4'b1000, 8'hFF});
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp after handshake", {30'd0, rsp_valid[0], cmd_ready[0]}, 32'd1);
        check("bp no early write", wen_total[0], w0);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        check("bp accepted write", {15'd0, rf_wen[0], rf_addr[0], rf_din[0]}, {15'd0, 1'b1, 8'h00, 8'h11});
        @(negedge clk);
        check("bp write rsp", {23'd0, rsp_valid[0], rsp_err[0], rsp_data[0]}, {23'd0, 1'b1, 1'b0, 8'h00});
        @(negedge clk);
        check("bp mem r0", {24'd0, mem[0][0]}, 32'h11);

        // Reset while a SET is in RD_WAIT
        cmd_valid[0] = 1'b1; cmd_op[0] = RF_OP_SET; cmd_addr[0] = 8'h01; cmd_data[0] = 8'hF0;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        check("rst mid ren", {31'd0, rf_ren[0]}, 32'd1);
        w0 = wen_total[0];
        rst_n = 1'b0;
        #1;
        check("rst mid rsp", {22'd0, cmd_ready[0], rsp_valid[0], rsp_err[0], rsp_data[0]}, 32'd0);
        check("rst mid rf", {14'd0, rf_ren[0], rf_wen[0], rf_addr[0], rf_din[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst mid no write", wen_total[0], w0);
        check("rst mid mem r1", {24'd0, mem[0][1]}, 32'h5A);
        check("rst mid ready", {31'd0, cmd_ready[0]}, 32'd1);
        run_cmd(0, RF_OP_READ, 8'h01, 8'h00, d, e, lat, ren_n, wen_n, din_w, addr_ok);
        check("rst recover read", {24'd0, d}, 32'h5A);
        check("rst recover latency", lat, 2);

        check("ren/wen overlap", overlap[0] + overlap[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
